harris_frame_ctrl: RTL and testbench

Frame-level sequencer for the Harris corner pipeline. On `start` it reads one IMG_W x IMG_H 8-bit frame from a pixel memory in raster order and drives the pipeline's pixel/pixel_valid input. It tracks each returned harris_score and assigns window coordinates to it. Scores above a programmable threshold are emitted as corner events; the block reports done, corner count and timeout error.

---
 rtl/harris_frame_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_harris_frame_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harris_frame_ctrl.sv
// ---------------------------------------------------------------------------
// harris_frame_ctrl
//
// Frame-level sequencer for the Harris corner pipeline. A start pulse fetches
// one IMG_W x IMG_H 8-bit frame from pixel memory in raster order and streams
// it into the pipeline. Returned scores are numbered in raster order over the
// (IMG_W-5) x (IMG_H-5) window grid. Scores strictly above the latched signed
// threshold become one-cycle corner events.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, abort        frame start pulse / return-to-idle request
//   threshold           signed corner threshold, latched on accepted start
//   mem_rd_en, mem_addr pixel memory read strobe and address
//   mem_rdata           read data, valid the cycle after mem_rd_en
//   pixel, pixel_valid  pixel stream into the Harris pipeline
//   score, score_valid  harris_score returned by the pipeline
//   corner_*            corner event (1 cycle after its score) and its data
//   corner_count        corners found in the current/last frame (saturating)
//   busy, done          frame in progress / one-cycle completion pulse
//   timeout_err         sticky: drain phase gave up waiting for scores
// ---------------------------------------------------------------------------
module harris_frame_ctrl #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int DRAIN_MAX = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic signed [31:0] threshold,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic [7:0]         pixel,
  output logic               pixel_valid,
  input  logic signed [31:0] score,
  input  logic               score_valid,
  output logic               corner_valid,
  output logic [15:0]        corner_x,
  output logic [15:0]        corner_y,
  output logic signed [31:0] corner_score,
  output logic [15:0]        corner_count,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int RX_W   = ADDR_W + 1;
  localparam int IDLE_W = $clog2(DRAIN_MAX + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [RX_W-1:0]   EXP_RX    = RX_W'((IMG_W - 5) * (IMG_H - 5));
  localparam logic [15:0]       SX_LAST   = 16'(IMG_W - 6);
  localparam logic [IDLE_W-1:0] DRAIN_LIM = IDLE_W'(DRAIN_MAX);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic signed [31:0] thr_q, thr_d;
  logic [RX_W-1:0]    rx_q, rx_d;
  logic [15:0]        sx_q, sx_d, sy_q, sy_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               cv_q, cv_d;
  logic [15:0]        cx_q, cx_d, cy_q, cy_d;
  logic signed [31:0] cs_q, cs_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               terr_q, terr_d;

  logic active, start_ok, accept, hit;

  assign active   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign start_ok = start && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Scores beyond the expected window count are dropped so coordinates never
  // run past the last window.
  assign accept   = active && score_valid && (rx_q != EXP_RX);
  assign hit      = accept && (score > thr_q);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    pixel_valid_d = (state_q == S_FETCH);
    thr_d         = thr_q;
    rx_d          = rx_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    idle_d        = idle_q;
    cv_d          = 1'b0;
    cx_d          = cx_q;
    cy_d          = cy_q;
    cs_d          = cs_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    terr_d        = terr_q;

    if (accept) begin
      rx_d = rx_q + 1'b1;
      if (sx_q == SX_LAST) begin
        sx_d = 16'd0;
        sy_d = sy_q + 16'd1;
      end else begin
        sx_d = sx_q + 16'd1;
      end
    end

    if (hit) begin
      cv_d  = 1'b1;
      cx_d  = sx_q;
      cy_d  = sy_q;
      cs_d  = score;
      cnt_d = sat_inc16(cnt_q);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = S_FETCH;
          thr_d   = threshold;
          addr_d  = '0;
          rx_d    = '0;
          sx_d    = 16'd0;
          sy_d    = 16'd0;
          idle_d  = '0;
          cnt_d   = 16'd0;
          terr_d  = 1'b0;
        end
      end
      S_FETCH: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          idle_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        idle_d = score_valid ? '0 : idle_q + 1'b1;
        // rx_d already includes a score accepted this cycle, so the final
        // score and the exit to DONE share the same cycle.
        if (rx_d == EXP_RX) begin
          state_d = S_DONE;
        end else if (idle_d == DRAIN_LIM) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything else, including a same-cycle start; counters
    // and corner_count are left as they are.
    if (abort) begin
      state_d       = S_IDLE;
      pixel_valid_d = 1'b0;
    end

    done_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      pixel_valid_q <= 1'b0;
      thr_q         <= '0;
      rx_q          <= '0;
      sx_q          <= 16'd0;
      sy_q          <= 16'd0;
      idle_q        <= '0;
      cv_q          <= 1'b0;
      cx_q          <= 16'd0;
      cy_q          <= 16'd0;
      cs_q          <= '0;
      cnt_q         <= 16'd0;
      done_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pixel_valid_q <= pixel_valid_d;
      thr_q         <= thr_d;
      rx_q          <= rx_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      idle_q        <= idle_d;
      cv_q          <= cv_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      cs_q          <= cs_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      terr_q        <= terr_d;
    end
  end

  assign mem_rd_en    = (state_q == S_FETCH);
  assign mem_addr     = addr_q;
  // Read data arrives the cycle after the strobe, which is exactly the cycle
  // pixel_valid (the strobe delayed by one) is high; qualify it so the pixel
  // bus is zero whenever no pixel is being presented.
  assign pixel        = pixel_valid_q ? mem_rdata : 8'd0;
  assign pixel_valid  = pixel_valid_q;
  assign corner_valid = cv_q;
  assign corner_x     = cx_q;
  assign corner_y     = cy_q;
  assign corner_score = cs_q;
  assign corner_count = cnt_q;
  assign busy         = active;
  assign done         = done_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_harris_frame_ctrl.sv
module tb_harris_frame_ctrl;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int AW   = 8;
  localparam int DM   = 32;
  localparam int NPIX = W * H;
  localparam int CW   = W - 5;
  localparam int EXP  = (W - 5) * (H - 5);

  logic               clk = 1'b0;
  logic               reset, start, abort;
  logic signed [31:0] threshold;
  logic               mem_rd_en;
  logic [AW-1:0]      mem_addr;
  logic [7:0]         mem_rdata;
  logic [7:0]         pixel;
  logic               pixel_valid;
  logic signed [31:0] score;
  logic               score_valid;
  logic               corner_valid;
  logic [15:0]        corner_x, corner_y, corner_count;
  logic signed [31:0] corner_score;
  logic               busy, done, timeout_err;

  harris_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DRAIN_MAX(DM)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .threshold(threshold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid), .score(score), .score_valid(score_valid),
    .corner_valid(corner_valid), .corner_x(corner_x), .corner_y(corner_y),
    .corner_score(corner_score), .corner_count(corner_count), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: one-cycle read latency.
  logic [7:0] mem [NPIX];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 8'($urandom);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Monitor: pixel runs, corner events, done pulses.
  int  run_idx = 0, last_run = 0, pix_bad = 0, done_cnt = 0, done_cyc = 0;
  int  last_rd_cyc = 0, rd_rise = 0, pv_rise = 0;
  logic pv_prev = 1'b0, rd_prev = 1'b0;
  int  ox[$], oy[$], oc[$];
  logic signed [31:0] os[$];

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (pixel !== mem[pv_prev ? run_idx : 0]) pix_bad <= pix_bad + 1;
      run_idx <= (pv_prev ? run_idx : 0) + 1;
      if (!pv_prev) pv_rise <= cyc;
    end else if (pv_prev) begin
      last_run <= run_idx;
    end
    pv_prev <= pixel_valid;
    if (mem_rd_en) last_rd_cyc <= cyc;
    if (mem_rd_en && !rd_prev) rd_rise <= cyc;
    rd_prev <= mem_rd_en;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (corner_valid) begin
      ox.push_back(int'(corner_x));
      oy.push_back(int'(corner_y));
      os.push_back(corner_score);
      oc.push_back(cyc);
    end
  end

  logic signed [31:0] sc_q[$];
  int s_cyc[$];

  // Pipeline stand-in: after the first pixel, wait lat cycles, then return
  // the queued scores with random gaps of up to maxgap cycles.
  task automatic send_scores(input int lat, input int maxgap);
    int k = 0;
    while (!pixel_valid && k < 500) begin
      @(posedge clk); #1; k++;
    end
    repeat (lat) begin @(posedge clk); #1; end
    foreach (sc_q[i]) begin
      int gap;
      score_valid = 1'b1;
      score = sc_q[i];
      s_cyc.push_back(cyc);
      @(posedge clk); #1;
      score_valid = 1'b0;
      score = $urandom;
      gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_addr(input string tag, input int a);
    bit ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      if (mem_rd_en && int'(mem_addr) == a) ok = 1'b1;
    end
    check_eq(tag, ok, 1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_rd_en"}, mem_rd_en, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_pixel"}, pixel, 0);
    check_eq({tag, "_pv"}, pixel_valid, 0);
    check_eq({tag, "_cv"}, corner_valid, 0);
    check_eq({tag, "_cx"}, corner_x, 0);
    check_eq({tag, "_cy"}, corner_y, 0);
    check_eq({tag, "_cs"}, corner_score, 0);
    check_eq({tag, "_cnt"}, corner_count, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_terr"}, timeout_err, 0);
  endtask

  task automatic pulse_start(input logic signed [31:0] thr);
    @(posedge clk); #1;
    start = 1'b1;
    threshold = thr;
    @(posedge clk); #1;
    start = 1'b0;
    threshold = $urandom;  // must have been latched already
    check_eq("start_busy", busy, 1);
    check_eq("start_addr0", mem_addr, 0);
    check_eq("start_terr_clr", timeout_err, 0);
    check_eq("start_cnt_clr", corner_count, 0);
  endtask

  // One full frame checked against a reference built from the score list.
  task automatic run_frame(input logic signed [31:0] thr, input int lat,
                           input int maxgap, input bit inject);
    int b_done, b_corn, b_bad, exp_n, k, last_s;
    bit exp_to;
    // spurious scores while idle must not count
    @(posedge clk); #1;
    score_valid = 1'b1; score = 32'sd100000;
    @(posedge clk); #1;
    score_valid = 1'b0;
    s_cyc.delete();
    b_done = done_cnt; b_corn = ox.size(); b_bad = pix_bad;
    pulse_start(thr);
    fork
      send_scores(lat, maxgap);
      begin
        if (inject) begin
          bit ok = 1'b0;
          wait_addr("inj_fetch", 30);
          start = 1'b1; @(negedge clk); start = 1'b0;
          for (int j = 0; j < 500 && !ok; j++) begin
            @(negedge clk);
            if (busy && !mem_rd_en) ok = 1'b1;
          end
          check_eq("inj_drain", ok, 1);
          start = 1'b1; @(negedge clk); start = 1'b0;
        end
      end
      begin
        k = 0;
        while (done_cnt == b_done && k < 3000) begin @(negedge clk); k++; end
      end
    join
    @(negedge clk); @(negedge clk);
    check_eq("done_pulses", done_cnt - b_done, 1);
    check_eq("pix_run_len", last_run, NPIX);
    check_eq("pix_data_bad", pix_bad - b_bad, 0);
    check_eq("pv_latency", pv_rise - rd_rise, 1);
    check_eq("busy_end", busy, 0);
    exp_n = 0;
    for (int i = 0; i < sc_q.size() && i < EXP; i++) begin
      if (sc_q[i] > thr) begin
        if (b_corn + exp_n < ox.size()) begin
          check_eq("corner_x", ox[b_corn + exp_n], i % CW);
          check_eq("corner_y", oy[b_corn + exp_n], i / CW);
          check_eq("corner_score", os[b_corn + exp_n], sc_q[i]);
          check_eq("corner_lat", oc[b_corn + exp_n] - s_cyc[i], 1);
        end
        exp_n++;
      end
    end
    check_eq("n_corners", ox.size() - b_corn, exp_n);
    check_eq("corner_count", corner_count, exp_n);
    exp_to = (sc_q.size() < EXP);
    check_eq("timeout_err", timeout_err, exp_to);
    if (exp_to) begin
      last_s = (s_cyc.size() > 0 && s_cyc[$] > last_rd_cyc) ? s_cyc[$] : last_rd_cyc;
      check_eq("timeout_lat", done_cyc - last_s, DM + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_done, b_corn, abort_cyc, exp_n, cc;
    int ex2x[4] = '{2, 0, 1, 2};
    int ex2y[4] = '{1, 2, 2, 2};
    reset = 1'b1; start = 1'b0; abort = 1'b0; threshold = '0;
    score = '0; score_valid = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    reset = 1'b0;

    // All-zero scores, maximal threshold: no corners.
    sc_q.delete();
    for (int i = 0; i < EXP; i++) sc_q.push_back(32'sd0);
    run_frame(32'sh7FFFFFFF, 10, 0, 1'b0);

    // Scores 0..8 against threshold 4.
    sc_q.delete();
    for (int i = 0; i < EXP; i++) sc_q.push_back(32'(i));
    b_corn = ox.size();
    run_frame(32'sd4, 10, 0, 1'b0);
    if (ox.size() - b_corn == 4)
      for (int i = 0; i < 4; i++) begin
        check_eq("t2_x", ox[b_corn + i], ex2x[i]);
        check_eq("t2_y", oy[b_corn + i], ex2y[i]);
      end

    // Signed, strictly-greater compare around -1.
    sc_q.delete();
    for (int i = 0; i < EXP; i++) sc_q.push_back((i % 2) ? 32'sd0 : -32'sd1);
    run_frame(-32'sd1, 10, 1, 1'b0);

    // One score short: drain timeout, then cleared by the next start.
    sc_q.delete();
    for (int i = 0; i < EXP - 1; i++) sc_q.push_back(32'sd5);
    run_frame(32'sd0, 10, 0, 1'b0);

    // Extra scores past the window count are dropped.
    sc_q.delete();
    for (int i = 0; i < EXP + 2; i++) sc_q.push_back(32'(i + 1));
    run_frame(32'sd0, 2, 0, 1'b0);

    // Abort in FETCH at address 20.
    sc_q.delete();
    for (int i = 0; i < EXP; i++) sc_q.push_back(32'sd50);
    s_cyc.delete();
    b_done = done_cnt; b_corn = ox.size();
    pulse_start(-32'sd100);
    abort_cyc = 0;
    fork
      send_scores(2, 0);
      begin
        wait_addr("abort_wait", 20);
        abort = 1'b1;
        abort_cyc = cyc;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_rd_en", mem_rd_en, 0);
        check_eq("abort_pv", pixel_valid, 0);
      end
    join
    exp_n = 0;
    foreach (s_cyc[i]) if (s_cyc[i] < abort_cyc && i < EXP && sc_q[i] > -32'sd100) exp_n++;
    cc = int'(corner_count);
    repeat (5) @(negedge clk);
    check_eq("abort_cnt", corner_count, exp_n);
    check_eq("abort_cnt_hold", corner_count, cc);
    check_eq("abort_no_done", done_cnt - b_done, 0);

    // Refetch from address 0 after abort, with stray starts in FETCH and DRAIN.
    sc_q.delete();
    for (int i = 0; i < EXP; i++) sc_q.push_back(32'($urandom_range(0, 20)) - 32'sd10);
    run_frame(32'sd0, 10, 0, 1'b0);
    run_frame(32'sd2, 62, 1, 1'b1);

    // start together with abort in FETCH.
    b_done = done_cnt;
    pulse_start(32'sd0);
    wait_addr("sa_wait", 10);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check_eq("sa_busy", busy, 0);
    check_eq("sa_rd_en", mem_rd_en, 0);
    repeat (4) @(negedge clk);
    check_eq("sa_no_done", done_cnt - b_done, 0);
    check_eq("sa_idle", busy, 0);

    // Reset mid-frame after some corners were produced.
    sc_q.delete();
    for (int i = 0; i < EXP; i++) sc_q.push_back(32'sd77);
    pulse_start(32'sd1);
    fork
      send_scores(2, 0);
      begin
        wait_addr("mrst_wait", 40);
        reset = 1'b1;
      end
    join
    @(posedge clk); #1;
    check_reset("mrst");
    reset = 1'b0;

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      int n;
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
      n = $urandom_range(EXP - 1, EXP + 2);
      sc_q.delete();
      for (int i = 0; i < n; i++) sc_q.push_back(32'($urandom_range(0, 100)) - 32'sd50);
      run_frame(32'($urandom_range(0, 60)) - 32'sd30, $urandom_range(10, 75),
                $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
